// File: rtl/sop_sweep_pkg.sv
// Shared types, sizing constants and the exact reference function for the SOP error sweeper.
package sop_sweep_pkg;

    localparam int IN_W_D  = 4;
    localparam int OUT_W_D = IN_W_D / 2;
    localparam int PIT_D   = 6;
    localparam int ET_D    = 1;

    // Config word layout: {use[IN_W-1:0], pol[IN_W-1:0], act[OUT_W-1:0]}
    localparam int CFG_W   = 2 * IN_W_D + OUT_W_D;
    localparam int ACT_LSB = 0;
    localparam int POL_LSB = OUT_W_D;
    localparam int USE_LSB = OUT_W_D + IN_W_D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Wide enough for any operand width used here; callers truncate to OUT_W.
    function automatic logic [15:0] abs_diff_ref(input logic [15:0] a, input logic [15:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sop_eval.sv
// Combinational evaluator for a shared-product SOP: PIT literal-mask products ORed per output.
module sop_eval
    import sop_sweep_pkg::*;
#(
    parameter int IN_W  = IN_W_D,
    parameter int OUT_W = OUT_W_D,
    parameter int PIT   = PIT_D
) (
    input  logic [PIT*(2*IN_W+OUT_W)-1:0] cfg,
    input  logic [IN_W-1:0]               vec,
    output logic [OUT_W-1:0]              approx
);

    localparam int SLOT_W = 2 * IN_W + OUT_W;

    logic [PIT-1:0]            prod;
    logic [OUT_W-1:0][PIT-1:0] act_mat;

    genvar gi, gj;
    generate
        for (gi = 0; gi < PIT; gi++) begin : g_prod
            logic [SLOT_W-1:0] word;
            logic [IN_W-1:0]   use_m;
            logic [IN_W-1:0]   pol_m;
            assign word  = cfg[gi*SLOT_W +: SLOT_W];
            assign use_m = word[OUT_W+IN_W +: IN_W];
            assign pol_m = word[OUT_W +: IN_W];
            // Unused literals contribute 1, so an empty product is constant 1.
            assign prod[gi] = &(~use_m | ~(pol_m ^ vec));
            for (gj = 0; gj < OUT_W; gj++) begin : g_act
                assign act_mat[gj][gi] = word[gj];
            end
        end
        for (gj = 0; gj < OUT_W; gj++) begin : g_out
            assign approx[gj] = |(prod & act_mat[gj]);
        end
    endgenerate

endmodule

// File: rtl/sop_error_sweeper.sv
// Loads a candidate SOP config and sweeps all input vectors, reporting worst error and violations.
// Optional macro SWEEP_TRACE_EN adds first_bad_vec/first_bad_vld capture of the first violating vector.
module sop_error_sweeper
    import sop_sweep_pkg::*;
#(
    parameter int IN_W  = IN_W_D,
    parameter int OUT_W = IN_W / 2,
    parameter int PIT   = PIT_D,
    parameter int ET    = ET_D
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [2*IN_W+OUT_W-1:0] cfg_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [OUT_W-1:0]        max_err,
    output logic [IN_W:0]           err_cnt,
    output logic                    pass
`ifdef SWEEP_TRACE_EN
    ,
    output logic [IN_W-1:0]         first_bad_vec,
    output logic                    first_bad_vld
`endif
);

    localparam int SLOT_W = 2 * IN_W + OUT_W;
    localparam int IDX_W  = (PIT > 1) ? $clog2(PIT) : 1;
    localparam int HW     = IN_W / 2;

    state_t            state_reg;
    logic [IDX_W-1:0]  cfg_idx_reg;
    logic              cfg_full_reg;
    logic [IN_W-1:0]   vec_reg;
    logic              drain_cnt_reg;
    logic [PIT*SLOT_W-1:0] cfg_flat;
    logic [OUT_W-1:0]  approx;
    logic              cfg_wr;
    logic              start_acc;

    logic              s1_vld_reg;
    logic [OUT_W-1:0]  s1_exact_reg;
    logic [OUT_W-1:0]  s1_approx_reg;
    logic [OUT_W-1:0]  err;
    logic              err_bad;
    logic [OUT_W-1:0]  max_err_reg;
    logic [IN_W:0]     err_cnt_reg;

    assign cfg_wr    = cfg_ready && cfg_valid;
    // Uses cfg_full before this edge, so a same-cycle final config write cannot enable start.
    assign start_acc = (state_reg == ST_IDLE) && start && cfg_full_reg;

    genvar gi;
    generate
        for (gi = 0; gi < PIT; gi++) begin : g_slot
            logic [SLOT_W-1:0] slot_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    slot_reg <= '0;
                else if (cfg_wr && cfg_idx_reg == IDX_W'(gi))
                    slot_reg <= cfg_data;
            end
            assign cfg_flat[gi*SLOT_W +: SLOT_W] = slot_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cfg_idx_reg   <= '0;
            cfg_full_reg  <= 1'b0;
            vec_reg       <= '0;
            drain_cnt_reg <= 1'b0;
            cfg_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_wr) begin
                        if (cfg_idx_reg == IDX_W'(PIT - 1)) begin
                            cfg_idx_reg  <= '0;
                            cfg_full_reg <= 1'b1;
                        end else begin
                            cfg_idx_reg <= cfg_idx_reg + 1'b1;
                        end
                    end
                    if (start_acc) begin
                        state_reg <= ST_SWEEP;
                        vec_reg   <= '0;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    vec_reg <= vec_reg + 1'b1;
                    if (vec_reg == '1) begin
                        state_reg     <= ST_DRAIN;
                        drain_cnt_reg <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_reg <= 1'b1;
                    if (drain_cnt_reg) begin
                        state_reg <= ST_DONE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    done      <= 1'b1;
                    cfg_ready <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    sop_eval #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .PIT   (PIT)
    ) u_eval (
        .cfg    (cfg_flat),
        .vec    (vec_reg),
        .approx (approx)
    );

    assign err     = (s1_exact_reg >= s1_approx_reg) ? (s1_exact_reg - s1_approx_reg)
                                                     : (s1_approx_reg - s1_exact_reg);
    assign err_bad = s1_vld_reg && (int'(err) > ET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_reg    <= 1'b0;
            s1_exact_reg  <= '0;
            s1_approx_reg <= '0;
            max_err_reg   <= '0;
            err_cnt_reg   <= '0;
        end else begin
            s1_vld_reg    <= (state_reg == ST_SWEEP);
            s1_exact_reg  <= OUT_W'(abs_diff_ref(16'(vec_reg[HW-1:0]), 16'(vec_reg[IN_W-1:HW])));
            s1_approx_reg <= approx;
            if (start_acc) begin
                max_err_reg <= '0;
                err_cnt_reg <= '0;
            end else if (s1_vld_reg) begin
                if (err > max_err_reg)
                    max_err_reg <= err;
                if (err_bad)
                    err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign max_err = max_err_reg;
    assign err_cnt = err_cnt_reg;
    assign pass    = (int'(max_err_reg) <= ET);

`ifdef SWEEP_TRACE_EN
    logic [IN_W-1:0] s1_vec_reg;
    logic [IN_W-1:0] first_bad_vec_reg;
    logic            first_bad_vld_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vec_reg        <= '0;
            first_bad_vec_reg <= '0;
            first_bad_vld_reg <= 1'b0;
        end else begin
            s1_vec_reg <= vec_reg;
            if (start_acc) begin
                first_bad_vec_reg <= '0;
                first_bad_vld_reg <= 1'b0;
            end else if (err_bad && !first_bad_vld_reg) begin
                first_bad_vec_reg <= s1_vec_reg;
                first_bad_vld_reg <= 1'b1;
            end
        end
    end

    assign first_bad_vec = first_bad_vec_reg;
    assign first_bad_vld = first_bad_vld_reg;
`endif

endmodule
